// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: walks a fixed 10-entry codec register table, issuing one I2C write per entry
module codec_config_sequencer #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h1A,
  parameter int         GAP_CYCLES    = 2048,
  parameter int         START_TIMEOUT = 4096,
  parameter int         XFER_TIMEOUT  = 65536
) (
  input  logic       i_clock_50,
  input  logic       i_reset_n,
  input  logic       i_go,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [3:0] o_step,
  output logic       o_i2c_start,
  input  logic       i_i2c_communicating,
  output logic [6:0] o_i2c_slave_address,
  output logic [7:0] o_i2c_register_address,
  output logic [7:0] o_i2c_data_send,
  output logic       o_i2c_write,
  output logic       o_i2c_read
);
  localparam int MAX_T0 = START_TIMEOUT > XFER_TIMEOUT ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int MAX_T  = MAX_T0 > GAP_CYCLES ? MAX_T0 : GAP_CYCLES;
  localparam int TW     = $clog2(MAX_T);
  typedef enum logic [2:0] {IDLE, LOAD, REQ, XFER, GAP, DONE, ERROR} state_t;
  state_t          r_state, w_state;
  logic [3:0]      r_step, w_step;
  logic            r_busy, w_busy, r_done, w_done, r_error, w_error, r_start, w_start;
  logic [7:0]      r_addr, w_addr, r_data, w_data;
  logic [TW-1:0]   r_timer, w_timer;
  logic [1:0]      r_sync;
  logic            w_comm;
  logic [15:0]     w_entry;
  assign w_comm = r_sync[1];
  // table entry {reg[6:0], data[8:0]} for the current step
  always_comb begin
    case (r_step)
      4'd0:    w_entry = 16'h1E00;
      4'd1:    w_entry = 16'h0017;
      4'd2:    w_entry = 16'h0217;
      4'd3:    w_entry = 16'h0479;
      4'd4:    w_entry = 16'h0679;
      4'd5:    w_entry = 16'h0812;
      4'd6:    w_entry = 16'h0A00;
      4'd7:    w_entry = 16'h0C00;
      4'd8:    w_entry = 16'h0E42;
      default: w_entry = 16'h1201;
    endcase
  end
  // next-state and registered-output logic; timer saturates and is cleared on every state entry
  always_comb begin
    w_state = r_state;
    w_step  = r_step;
    w_busy  = r_busy;
    w_done  = r_done;
    w_error = r_error;
    w_start = r_start;
    w_addr  = r_addr;
    w_data  = r_data;
    w_timer = &r_timer ? r_timer : r_timer + 1'b1;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (i_go) begin
          w_state = LOAD;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_error = 1'b0;
          w_step  = 4'd0;
          w_timer = '0;
        end
      end
      LOAD: begin
        w_addr = w_entry[15:8];
        w_data = w_entry[7:0];
        if (!w_comm) begin
          w_state = REQ;
          w_start = 1'b1;
          w_timer = '0;
        end
      end
      REQ: begin
        if (r_timer == TW'(START_TIMEOUT - 1)) begin
          w_state = ERROR;
          w_busy  = 1'b0;
          w_error = 1'b1;
          w_start = 1'b0;
          w_timer = '0;
        end else if (w_comm) begin
          w_state = XFER;
          w_start = 1'b0;
          w_timer = '0;
        end
      end
      XFER: begin
        if (r_timer == TW'(XFER_TIMEOUT - 1)) begin
          w_state = ERROR;
          w_busy  = 1'b0;
          w_error = 1'b1;
          w_timer = '0;
        end else if (!w_comm) begin
          w_state = GAP;
          w_timer = '0;
        end
      end
      GAP: begin
        if (r_timer == TW'(GAP_CYCLES - 1)) begin
          w_timer = '0;
          if (r_step == 4'd9) begin
            w_state = DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_state = LOAD;
            w_step  = r_step + 4'd1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end
  // state, outputs and the two-flop synchroniser for the slow-domain busy flag
  always_ff @(posedge i_clock_50 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_start <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_timer <= '0;
      r_sync  <= '0;
    end else begin
      r_state <= w_state;
      r_step  <= w_step;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_error <= w_error;
      r_start <= w_start;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_timer <= w_timer;
      r_sync  <= {r_sync[0], i_i2c_communicating};
    end
  end
  assign o_busy                 = r_busy;
  assign o_done                 = r_done;
  assign o_error                = r_error;
  assign o_step                 = r_step;
  assign o_i2c_start            = r_start;
  assign o_i2c_slave_address    = SLAVE_ADDR;
  assign o_i2c_register_address = r_addr;
  assign o_i2c_data_send        = r_data;
  assign o_i2c_write            = 1'b1;
  assign o_i2c_read             = 1'b0;
endmodule
